mdu_seq_divider: RTL and testbench
==================================

// Module: mdu_seq_divider
// PURPOSE
//  Iterative radix-2 restoring divider, signed or unsigned, feeding the HI/LO unit for DIV/DIVU.
//  The HI/LO unit drives start/sign from the decoded mdu code; this block returns quotient/remainder
//  plus busy/over. over gates pc_ena (PC stall) and marks the edge on which {lo,hi} <= {q,r}.
// PARAMETERS
//  WIDTH  32  operand, quotient and remainder width in bits; iteration count = WIDTH
// PORTS
//  clk       in   1      single clock; all state changes on posedge clk
//  reset     in   1      synchronous, active-high; also driven high by HI/LO unit when mdu is not a divide
//  start     in   1      request; sampled only in IDLE or DONE
//  sign      in   1      1 = signed (DIV), 0 = unsigned (DIVU); captured with start
//  dividend  in   WIDTH  rs operand; captured with start
//  divisor   in   WIDTH  rt operand; captured with start
//  q         out  WIDTH  quotient, valid while over=1, held until next accepted start
//  r         out  WIDTH  remainder, same validity as q
//  busy      out  1      1 while iterating
//  over      out  1      1 in DONE: result valid
// BEHAVIOUR
//  Reset (sync): state=IDLE, q=0, r=0, busy=0, over=0, counter=0. Reset mid-operation aborts, no result.
//  States: IDLE -start-> BUSY; BUSY -counter==WIDTH-1-> DONE; DONE -start-> BUSY; DONE stays otherwise.
//  Accept: start=1 in IDLE/DONE latches operands and sign; busy=1, over=0 from next cycle.
//  start while BUSY ignored; operands changing while BUSY ignored.
//  Latency: start at edge N -> busy high cycles N+1..N+WIDTH -> over=1 from edge N+WIDTH+1 (33 cycles @32).
//  over is level, not pulse: held in DONE so HI/LO may sample repeatedly; busy and over never both 1.
//  Signed: operate on magnitudes (|x| computed in WIDTH+1 bits, so 0x80000000 is exact).
//   quotient negated iff sign(dividend)!=sign(divisor); remainder takes sign of dividend.
//  Iteration: partial remainder WIDTH+1 bits; shift in next dividend MSB, trial-subtract |divisor|;
//   if non-negative keep and set quotient bit 1, else restore and bit 0. Counter 0..WIDTH-1.
//  Divide by zero (divisor==0): completes with normal latency; q=all ones, r=dividend (raw input bits).
//  Signed overflow 0x80000000 / 0xFFFFFFFF: q=0x80000000, r=0 (falls out of magnitude path; must hold).
//  start and reset same cycle: reset wins.
// STRUCTURE
//  Shared package mdu_pkg: mdu op codes (MDU_NONE=0, MULT=1, MULTU=2, DIV=3, DIVU=4, MTHI=5, MTLO=6),
//   divider state enum {DIV_IDLE, DIV_BUSY, DIV_DONE}, DIV_WIDTH=32.
//  Sub-module div_step: combinational one-iteration shift/trial-subtract/restore
//   (inputs: partial rem, divisor mag, next bit; outputs: new rem, q bit).
//  Top: FSM, counter, operand/sign capture, magnitude conversion, final sign fix-up, zero-divisor override.
// TESTING
//  unsigned 100/7, sign=0 -> over after 33 cycles, q=14, r=2; busy high exactly 32 cycles.
//  signed -7/2 (0xFFFFFFF9, 2), sign=1 -> q=0xFFFFFFFD (-3), r=0xFFFFFFFF (-1); 7/-2 -> q=-3, r=1.
//  divisor=0, dividend=0x1234, either sign -> q=0xFFFFFFFF, r=0x1234, normal latency.
//  signed 0x80000000/0xFFFFFFFF -> q=0x80000000, r=0; unsigned 0xFFFFFFFF/1 -> q=0xFFFFFFFF, r=0.
//  reset pulsed at cycle 10 of BUSY -> next cycle busy=0, over=0, q=r=0; fresh start then completes correctly.
//  back-to-back: start held high in DONE -> new op accepted, over drops next cycle; start during BUSY ignored.

Source files
------------

// File: rtl/mdu_pkg.sv
// mdu_pkg: shared multiply/divide unit op codes, divider states and widths
package mdu_pkg;
   localparam int DIV_WIDTH = 32;
   typedef enum logic [2:0] {
      MDU_NONE  = 3'd0,
      MDU_MULT  = 3'd1,
      MDU_MULTU = 3'd2,
      MDU_DIV   = 3'd3,
      MDU_DIVU  = 3'd4,
      MDU_MTHI  = 3'd5,
      MDU_MTLO  = 3'd6
   } mdu_op_e;
   typedef enum logic [1:0] {
      DIV_IDLE,
      DIV_BUSY,
      DIV_DONE
   } div_state_e;
endpackage

// File: rtl/div_step.sv
// div_step: one restoring-division iteration (shift in next bit, trial-subtract, restore)
module div_step #(
   parameter int WIDTH = 32
) (
   input  logic [WIDTH:0] rem_in,
   input  logic [WIDTH:0] dmag,
   input  logic           bit_in,
   output logic [WIDTH:0] rem_out,
   output logic           q_bit
);
   logic [WIDTH:0] shifted, diff;
   always_comb begin
      shifted = {rem_in[WIDTH-1:0], bit_in};
      diff    = shifted - dmag;
      q_bit   = ~diff[WIDTH];
      rem_out = diff[WIDTH] ? shifted : diff;
   end
endmodule

// File: rtl/mdu_seq_divider.sv
// mdu_seq_divider: iterative radix-2 restoring divider (signed/unsigned) for the HI/LO unit.
// Works on magnitudes and fixes signs on the final iteration; divide-by-zero returns q=all ones, r=dividend.
module mdu_seq_divider
   import mdu_pkg::*;
#(
   parameter int WIDTH = DIV_WIDTH
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic             sign,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
   output logic [WIDTH-1:0] q,
   output logic [WIDTH-1:0] r,
   output logic             busy,
   output logic             over
);
   localparam int CW = $clog2(WIDTH);
   div_state_e state, state_nx;
   logic [CW-1:0] cnt;
   logic [WIDTH:0] rem, dmag, rem_nx, a_ext, b_ext, a_mag, b_mag;
   logic [WIDTH-1:0] quo, raw_dvd, q_mag, q_fix, r_fix;
   logic q_bit, neg_q, neg_r, dvz, accept, last;

   assign busy   = state == DIV_BUSY;
   assign over   = state == DIV_DONE;
   assign accept = start && state != DIV_BUSY;
   assign last   = busy && cnt == CW'(WIDTH - 1);

   // Extending to WIDTH+1 bits makes the most negative operand's magnitude exact.
   always_comb begin
      a_ext = {sign & dividend[WIDTH-1], dividend};
      b_ext = {sign & divisor[WIDTH-1], divisor};
      a_mag = a_ext[WIDTH] ? -a_ext : a_ext;
      b_mag = b_ext[WIDTH] ? -b_ext : b_ext;
      q_mag = {quo[WIDTH-2:0], q_bit};
      q_fix = dvz ? '1 : (neg_q ? -q_mag : q_mag);
      r_fix = dvz ? raw_dvd : (neg_r ? -rem_nx[WIDTH-1:0] : rem_nx[WIDTH-1:0]);
   end

   div_step #(.WIDTH(WIDTH)) u_step (
      .rem_in (rem),
      .dmag   (dmag),
      .bit_in (quo[WIDTH-1]),
      .rem_out(rem_nx),
      .q_bit  (q_bit)
   );

   always_comb begin
      state_nx = state;
      if (accept) state_nx = DIV_BUSY;
      else if (last) state_nx = DIV_DONE;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state   <= DIV_IDLE;
         cnt     <= '0;
         rem     <= '0;
         dmag    <= '0;
         quo     <= '0;
         raw_dvd <= '0;
         neg_q   <= 1'b0;
         neg_r   <= 1'b0;
         dvz     <= 1'b0;
         q       <= '0;
         r       <= '0;
      end else begin
         state <= state_nx;
         if (accept) begin
            cnt     <= '0;
            rem     <= '0;
            dmag    <= b_mag;
            quo     <= a_mag[WIDTH-1:0];
            raw_dvd <= dividend;
            neg_q   <= sign && (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
            neg_r   <= sign && dividend[WIDTH-1];
            dvz     <= divisor == '0;
         end else if (busy) begin
            cnt <= cnt + CW'(1);
            rem <= rem_nx;
            quo <= q_mag;
            if (last) begin
               q <= q_fix;
               r <= r_fix;
            end
         end
      end
   end
endmodule

// File: tb/tb_mdu_seq_divider.sv
// tb_mdu_seq_divider: directed vectors with hand-computed quotient/remainder and latency checks
module tb_mdu_seq_divider;
   logic        clk = 1'b0;
   logic        reset, start, sign;
   logic [31:0] dividend, divisor, q, r;
   logic        busy, over;
   int          checks = 0;
   int          errors = 0;
   logic        both_seen = 1'b0;
   int          cyc, bcnt;

   mdu_seq_divider dut (
      .clk     (clk),
      .reset   (reset),
      .start   (start),
      .sign    (sign),
      .dividend(dividend),
      .divisor (divisor),
      .q       (q),
      .r       (r),
      .busy    (busy),
      .over    (over)
   );

   always #5 clk = ~clk;

   always @(negedge clk) if (busy && over) both_seen = 1'b1;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   // Raise start before an edge, then count edges until over rises.
   task automatic run(input logic [31:0] a, input logic [31:0] b, input logic s,
                      output int c, output int bc);
      @(negedge clk);
      dividend = a; divisor = b; sign = s; start = 1'b1;
      c = 0; bc = 0;
      do begin
         @(posedge clk); #1;
         start = 1'b0;
         c++;
         if (busy) bc++;
      end while (!over && c < 200);
   endtask

   task automatic div_chk(input string tag, input logic [31:0] a, input logic [31:0] b,
                          input logic s, input logic [31:0] eq, input logic [31:0] er);
      run(a, b, s, cyc, bcnt);
      chk({tag, "_q"}, q, eq);
      chk({tag, "_r"}, r, er);
      chk({tag, "_lat"}, cyc, 33);
   endtask

   initial begin
      reset = 1'b1; start = 1'b0; sign = 1'b0; dividend = '0; divisor = '0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_busy", {31'd0, busy}, 0);
      chk("rst_over", {31'd0, over}, 0);
      chk("rst_q", q, 0);
      chk("rst_r", r, 0);
      @(negedge clk); reset = 1'b0;

      run(100, 7, 1'b0, cyc, bcnt);
      chk("u100_7_q", q, 14);
      chk("u100_7_r", r, 2);
      chk("u100_7_lat", cyc, 33);
      chk("u100_7_busy", bcnt, 32);
      repeat (3) @(posedge clk);
      #1;
      chk("over_held", {31'd0, over}, 1);
      chk("q_held", q, 14);

      div_chk("s_m7_2", 32'hFFFF_FFF9, 32'd2, 1'b1, 32'hFFFF_FFFD, 32'hFFFF_FFFF);
      div_chk("s_7_m2", 32'd7, 32'hFFFF_FFFE, 1'b1, 32'hFFFF_FFFD, 32'd1);
      div_chk("u_dz", 32'h1234, 32'd0, 1'b0, 32'hFFFF_FFFF, 32'h1234);
      div_chk("s_dz", 32'h1234, 32'd0, 1'b1, 32'hFFFF_FFFF, 32'h1234);
      div_chk("s_ovf", 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 32'h8000_0000, 32'd0);
      div_chk("u_max_1", 32'hFFFF_FFFF, 32'd1, 1'b0, 32'hFFFF_FFFF, 32'd0);
      div_chk("u_big", 32'hFFFF_FFF9, 32'd2, 1'b0, 32'h7FFF_FFFC, 32'd1);

      // Reset ten cycles into BUSY, with start asserted alongside it.
      @(negedge clk);
      dividend = 1000; divisor = 3; sign = 1'b0; start = 1'b1;
      @(negedge clk); start = 1'b0;
      repeat (9) @(negedge clk);
      chk("mid_busy", {31'd0, busy}, 1);
      reset = 1'b1; start = 1'b1;
      @(posedge clk); #1;
      chk("abort_busy", {31'd0, busy}, 0);
      chk("abort_over", {31'd0, over}, 0);
      chk("abort_q", q, 0);
      chk("abort_r", r, 0);
      reset = 1'b0; start = 1'b0;
      @(posedge clk); #1;
      chk("idle_after_rst", {31'd0, busy}, 0);
      div_chk("fresh", 32'd1000, 32'd3, 1'b0, 32'd333, 32'd1);

      // Start held in DONE with new operands; later starts/operand changes while BUSY ignored.
      @(negedge clk);
      dividend = 200; divisor = 9; sign = 1'b0; start = 1'b1;
      @(posedge clk); #1;
      chk("b2b_over_drop", {31'd0, over}, 0);
      chk("b2b_busy", {31'd0, busy}, 1);
      dividend = 32'hDEAD_BEEF; divisor = 5; sign = 1'b1;
      repeat (4) @(posedge clk);
      #1;
      start = 1'b0;
      cyc = 5;
      while (!over && cyc < 200) begin
         @(posedge clk); #1;
         cyc++;
      end
      chk("b2b_q", q, 22);
      chk("b2b_r", r, 2);
      chk("b2b_lat", cyc, 33);
      chk("busy_over_excl", {31'd0, both_seen}, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
